instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage for the single-issue MIPS core.
- Owns the PC, drives the combinational instruction-memory read port (8-bit byte address, 32-bit word), and registers each fetched word into a one-entry fetch buffer.
- Hands the buffered word to decode with a valid/ready handshake.
- Resolves unconditional jumps (op 000010) locally, accepts branch redirects from execute, and halts on syscall (op 001100).

Parameters:
- ADDR_W, 8, PC / instruction-memory byte-address width.
- RESET_PC, 0, PC value loaded on reset.
- OP_J, 6'b000010, opcode resolved as a jump inside fetch.
- OP_SYSCALL, 6'b001100, opcode that halts fetch.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_W  byte address to instruction memory; equals the pc register.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  execute requests a PC change (taken beq).
- redirect_pc  input  ADDR_W  new PC for the redirect.
- inst_ready  input  1  decode accepts the buffered instruction this cycle.
- inst_valid  output  1  fetch buffer holds a valid instruction.
- inst  output  32  buffered instruction word.
- inst_pc  output  ADDR_W  byte address of the buffered instruction.
- pc_plus4  output  ADDR_W  inst_pc + 4, mod 2^ADDR_W.
- halted  output  1  syscall fetched; fetch stopped.

Behaviour:
- Single clock, asynchronous active-low reset.
- Reset values: pc = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0, halted = 0. Reset asserted mid-operation clears all state immediately. First fetch from RESET_PC occurs on the first rising edge after rst_n deasserts.
- imem_addr is combinational from pc only. It has no path from redirect_valid or imem_data.
- Definitions:
  - accept = inst_valid & inst_ready.
  - load = !halted & (!inst_valid | inst_ready).
- Per rising edge, highest priority first:
  1. redirect_valid = 1:
     - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are forced to 0.
     - inst_valid <= 0; the buffer is flushed even if it is not accepted.
     - halted <= 0.
     - One bubble cycle follows.
  2. Else if load:
     - inst <= imem_data, inst_pc <= pc, inst_valid <= 1.
     - Next pc:
       - imem_data[31:26] == OP_J: pc <= {imem_data[ADDR_W-3:0], 2'b00}. The target is a word index truncated to ADDR_W bits, so target 6 gives address 24.
       - imem_data[31:26] == OP_SYSCALL: pc holds and halted <= 1. The syscall word itself is delivered to decode.
       - otherwise: pc <= pc + 4, wrapping 252 -> 0 for ADDR_W = 8.
  3. Else if accept (only possible while halted): inst_valid <= 0.
  4. Otherwise all state holds. Under backpressure, inst, inst_pc and inst_valid stay stable and pc does not advance.
- Throughput: one instruction per cycle when inst_ready is held high. Fetch-to-valid latency is one cycle.
- The jump word is delivered to decode like any other instruction, so decode treats it as a nop. The word after a jump is never fetched; there are no delay slots.
- Simultaneous redirect_valid and inst_ready: the redirect wins. The buffered instruction is dropped, not delivered.
- While halted: no new fetches. A buffered syscall can still be accepted, after which inst_valid falls to 0 and stays 0. Only reset or redirect leaves halt.
- imem_data being X for an out-of-program address is captured as-is; fetch does not check it.
- pc_plus4 is combinational from inst_pc.

Test Plan:
- Reset then inst_ready = 1, imem returning words at 0, 4, 8 -> imem_addr sequence 0, 4, 8, 12; inst_valid rises one cycle after reset release; inst_pc follows 0, 4, 8.
- Hold inst_ready = 0 for 3 cycles with the instruction at 8 buffered -> inst and inst_pc = 8 stable, imem_addr stays 12; on release, inst_pc = 12 on the next cycle.
- Fetch 32'h08000006 at address 44 -> the next imem_addr is 24, not 48; the jump word is delivered with inst_pc = 44.
- redirect_valid with redirect_pc = 49 while inst_ready = 1 and the buffer is valid -> next imem_addr = 48; inst_valid is 0 for one cycle; the buffered word is not delivered.
- Fetch 32'h30000000 at address 56 -> halted = 1, imem_addr holds 56; the syscall is delivered once, then inst_valid stays 0; a later redirect to 0 clears halted and fetching resumes.
- Sequential fetch reaching pc = 252 -> next imem_addr = 0. Drop rst_n mid-stream -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// holds one fetched word in a buffer handed to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter logic [5:0]        OP_J       = 6'b000010,
    parameter logic [5:0]        OP_SYSCALL = 6'b001100
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(2'b11);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic              inst_valid_r;
    logic              inst_valid_next_s;
    logic [31:0]       inst_r;
    logic [31:0]       inst_next_s;
    logic [ADDR_W-1:0] inst_pc_r;
    logic [ADDR_W-1:0] inst_pc_next_s;
    logic              halted_r;
    logic              halted_next_s;
    logic              load_s;
    logic              accept_s;
    logic [5:0]        opcode_s;

    // Jump target is a word index truncated to the PC width, then scaled to bytes.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [31:0] word);
        return {word[ADDR_W-3:0], 2'b00};
    endfunction

    assign opcode_s = imem_data[31:26];
    assign accept_s = inst_valid_r & inst_ready;
    assign load_s   = ~halted_r & (~inst_valid_r | inst_ready);

    // Next-state selection: redirect beats a new fetch, which beats a plain drain.
    always_comb begin
        pc_next_s         = pc_r;
        inst_valid_next_s = inst_valid_r;
        inst_next_s       = inst_r;
        inst_pc_next_s    = inst_pc_r;
        halted_next_s     = halted_r;
        if (redirect_valid) begin
            pc_next_s         = redirect_pc & ~ALIGN_MASK;
            inst_valid_next_s = 1'b0;
            halted_next_s     = 1'b0;
        end else if (load_s) begin
            inst_next_s       = imem_data;
            inst_pc_next_s    = pc_r;
            inst_valid_next_s = 1'b1;
            case (opcode_s)
                OP_J:       pc_next_s     = jump_target(imem_data);
                OP_SYSCALL: halted_next_s = 1'b1;
                default:    pc_next_s     = pc_r + PC_STEP;
            endcase
        end else if (accept_s) begin
            inst_valid_next_s = 1'b0;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= {ADDR_W{1'b0}};
            halted_r     <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            inst_valid_r <= inst_valid_next_s;
            inst_r       <= inst_next_s;
            inst_pc_r    <= inst_pc_next_s;
            halted_r     <= halted_next_s;
        end
    end

    assign imem_addr  = pc_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign halted     = halted_r;
    assign pc_plus4   = inst_pc_r + PC_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed program walk, then randomized
// programs and handshakes compared against a behavioural fetch model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic [7:0]  pc_plus4;
    logic        halted;

    logic [31:0] mem [64];
    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    logic [7:0]  m_pc;
    logic [7:0]  m_ipc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_halt;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:2]];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc_plus4       (pc_plus4),
        .halted         (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_next_pc(input logic [7:0] pc, input logic [31:0] w);
        int unsigned op;
        op = w >> 26;
        if (op == 2) return 8'(((w % 64) * 4) % 256);
        if (op == 12) return pc;
        return 8'((int'(pc) + 4) % 256);
    endfunction

    // Behavioural fetch model, advanced once per clock from the architectural rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 8'd0;
            m_ipc   <= 8'd0;
            m_inst  <= 32'd0;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (redirect_valid) begin
            m_pc    <= 8'((int'(redirect_pc) / 4) * 4);
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
        end else if (!m_halt && (!m_valid || inst_ready)) begin
            m_inst  <= mem[m_pc[7:2]];
            m_ipc   <= m_pc;
            m_valid <= 1'b1;
            m_pc    <= model_next_pc(m_pc, mem[m_pc[7:2]]);
            m_halt  <= ((mem[m_pc[7:2]] >> 26) == 32'd12);
        end else if (m_valid && inst_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic compare_model();
        check_eq("m_imem_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("m_inst_valid", 32'(inst_valid), 32'(m_valid));
        check_eq("m_halted", 32'(halted), 32'(m_halt));
        if (m_valid) begin
            check_eq("m_inst", inst, m_inst);
            check_eq("m_inst_pc", 32'(inst_pc), 32'(m_ipc));
            check_eq("m_pc_plus4", 32'(pc_plus4), (int'(m_ipc) + 4) % 256);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic expect_fetch(input string tag, input logic v, input int ipc, input int addr);
        check_eq({tag, "_valid"}, 32'(inst_valid), 32'(v));
        if (v) check_eq({tag, "_inst_pc"}, 32'(inst_pc), ipc);
        check_eq({tag, "_imem_addr"}, 32'(imem_addr), addr);
    endtask

    function automatic logic [31:0] ord_word();
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = ord_word();
        mem[11] = 32'h0800_0006;
        mem[14] = 32'h3000_0000;
        rst_n          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_inst_pc", 32'(inst_pc), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        rst_n      = 1'b1;
        inst_ready = 1'b1;

        step(); expect_fetch("seq0", 1'b1, 0, 4);
        step(); expect_fetch("seq4", 1'b1, 4, 8);
        step(); expect_fetch("seq8", 1'b1, 8, 12);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_fetch("stall", 1'b1, 8, 12);
            check_eq("stall_inst", inst, mem[2]);
        end
        inst_ready = 1'b1;
        step(); expect_fetch("release", 1'b1, 12, 16);
        for (int a = 16; a <= 44; a += 4) begin
            step();
            check_eq("walk_inst_pc", 32'(inst_pc), a);
        end
        check_eq("jump_word", inst, 32'h0800_0006);
        check_eq("jump_target", 32'(imem_addr), 32'd24);
        step(); expect_fetch("after_jump", 1'b1, 24, 28);

        redirect_valid = 1'b1;
        redirect_pc    = 8'd49;
        step(); expect_fetch("redirect", 1'b0, 0, 48);
        redirect_valid = 1'b0;
        step(); expect_fetch("redir48", 1'b1, 48, 52);
        step(); expect_fetch("redir52", 1'b1, 52, 56);
        step(); expect_fetch("syscall", 1'b1, 56, 56);
        check_eq("syscall_word", inst, 32'h3000_0000);
        check_eq("syscall_halted", 32'(halted), 32'd1);
        step(); expect_fetch("halt_drain", 1'b0, 0, 56);
        step(); expect_fetch("halt_idle", 1'b0, 0, 56);
        check_eq("halt_hold", 32'(halted), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 8'd0;
        step(); expect_fetch("unhalt", 1'b0, 0, 0);
        check_eq("unhalt_halted", 32'(halted), 32'd0);
        redirect_valid = 1'b0;
        step(); expect_fetch("resume", 1'b1, 0, 4);

        redirect_valid = 1'b1;
        redirect_pc    = 8'd248;
        step(); expect_fetch("to248", 1'b0, 0, 248);
        redirect_valid = 1'b0;
        step(); expect_fetch("at248", 1'b1, 248, 252);
        step(); expect_fetch("wrap", 1'b1, 252, 0);
        check_eq("wrap_pc_plus4", 32'(pc_plus4), 32'd0);

        // Randomized programs, backpressure and redirects.
        for (int i = 0; i < 64; i++) begin
            int r;
            r = $urandom_range(0, 31);
            if (r < 2)       mem[i] = {6'b000010, 26'($urandom)};
            else if (r == 2) mem[i] = {6'b001100, 26'($urandom)};
            else             mem[i] = ord_word();
        end
        for (int c = 0; c < 3000; c++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 8'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a cycle with a valid buffer.
        mem[25] = ord_word();
        redirect_valid = 1'b1;
        redirect_pc    = 8'd100;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        step(); expect_fetch("pre_reset", 1'b1, 100, 104);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_valid", 32'(inst_valid), 32'd0);
        check_eq("async_inst", inst, 32'd0);
        check_eq("async_inst_pc", 32'(inst_pc), 32'd0);
        check_eq("async_halted", 32'(halted), 32'd0);
        check_eq("async_imem_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        compare_model();
        rst_n = 1'b1;
        step(); expect_fetch("post_reset", 1'b1, 0, int'(model_next_pc(8'd0, mem[0])));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
